// File: rtl/mmc_pkg.sv
// Shared encodings and CRC16 helpers for the MMC DAT receive path.
package mmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_DATA       = 3'd2,
    ST_CRC        = 3'd3,
    ST_ENDBIT     = 3'd4,
    ST_END        = 3'd5
  } mmc_rx_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int          CRC_LEN    = 16;

  // One serial step of CRC16-CCITT (x^16+x^12+x^5+1), data bit enters at the top.
  function automatic logic [CRC_LEN-1:0] crc16_step(input logic [CRC_LEN-1:0] crc,
                                                    input logic              b);
    logic fb;
    fb = crc[CRC_LEN-1] ^ b;
    return {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
  endfunction

endpackage

// File: rtl/mmc_crc16_rx.sv
// Serial CRC16 accumulator for one DAT line; updates on enable_i, 1-cycle latency.
// No backpressure: clear_i has priority over enable_i.
module mmc_crc16_rx
  import mmc_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic               bitval_i,
  output logic [CRC_LEN-1:0] crc_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_o <= '0;
    end else if (clear_i) begin
      crc_o <= '0;
    end else if (enable_i) begin
      crc_o <= crc16_step(crc_o, bitval_i);
    end
  end

endmodule

// File: rtl/mmc_dat_deserialiser.sv
// Receives one MMC DAT block (1/4-bit), emits bytes with a one-cycle valid strobe, checks CRC16/end bit.
// Byte strobe 1 cycle after its last sample edge, complete 2 cycles after end bit; no backpressure.
module mmc_dat_deserialiser
  import mmc_pkg::*;
#(
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT_W   = 24
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bitclk_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       mode_4bit_i,
  input  logic [3:0] dat_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       active_o,
  output logic       complete_o,
  output logic       crc_err_o,
  output logic       timeout_o
);

  localparam int                BCNT_W    = $clog2(BLOCK_BYTES) + 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BLOCK_BYTES - 1);

  mmc_rx_state_e state_q, state_d;

  logic                 clk_q;
  logic                 sample_w;
  logic                 mode4_q;
  logic [7:0]           byte_q;
  logic [7:0]           byte_nxt;
  logic [2:0]           sub_q;
  logic [BCNT_W-1:0]    bcnt_q;
  logic [3:0]           crcbit_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [TIMEOUT_W-1:0] tmo_nxt;
  logic [3:0][CRC_LEN-1:0] rx_crc_q;
  logic [3:0][CRC_LEN-1:0] calc_crc;
  logic [3:0]           crc_en;

  logic start_acc;
  logic data_edge;
  logic crc_edge;
  logic byte_done;
  logic tmo_hit;
  logic tmo_inc;
  logic end_chk;
  logic end_ok;
  logic crc_bad;
  logic cmpl_set;

  assign sample_w  = bitclk_i & ~clk_q;
  assign start_acc = (state_q == ST_IDLE) & start_i & ~abort_i;
  assign data_edge = (state_q == ST_DATA) & sample_w & ~abort_i;
  assign crc_edge  = (state_q == ST_CRC) & sample_w & ~abort_i;
  assign tmo_nxt   = tmo_q + TIMEOUT_W'(1);
  assign byte_nxt  = mode4_q ? {byte_q[3:0], dat_i} : {byte_q[6:0], dat_i[0]};
  assign active_o  = (state_q != ST_IDLE);

  // In 1-bit mode lines 1..3 carry nothing we care about: keep their engines idle.
  for (genvar g = 0; g < 4; g++) begin : g_line
    localparam bit LINE0 = (g == 0);
    assign crc_en[g] = data_edge & (mode4_q | LINE0);
    mmc_crc16_rx u_crc (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (start_acc),
      .enable_i(crc_en[g]),
      .bitval_i(dat_i[g]),
      .crc_o   (calc_crc[g])
    );
  end

  assign end_ok  = mode4_q ? (&dat_i) : dat_i[0];
  assign crc_bad = ~end_ok
                 | (rx_crc_q[0] != calc_crc[0])
                 | (mode4_q & ((rx_crc_q[1] != calc_crc[1]) |
                               (rx_crc_q[2] != calc_crc[2]) |
                               (rx_crc_q[3] != calc_crc[3])));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    byte_done = 1'b0;
    tmo_hit   = 1'b0;
    tmo_inc   = 1'b0;
    end_chk   = 1'b0;
    cmpl_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (sample_w) begin
          if (!dat_i[0]) begin
            state_d = ST_DATA;
          end else begin
            tmo_inc = 1'b1;
            if (&tmo_nxt) begin
              tmo_hit = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_DATA: begin
        if (sample_w) begin
          byte_done = mode4_q ? (sub_q == 3'd1) : (sub_q == 3'd7);
          if (byte_done && (bcnt_q == LAST_BYTE)) state_d = ST_CRC;
        end
      end
      ST_CRC: begin
        if (sample_w && (crcbit_q == 4'd15)) state_d = ST_ENDBIT;
      end
      ST_ENDBIT: begin
        if (sample_w) begin
          end_chk = 1'b1;
          state_d = ST_END;
        end
      end
      ST_END: begin
        cmpl_set = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort beats every other transition and suppresses all side effects.
    if (abort_i) begin
      state_d   = ST_IDLE;
      byte_done = 1'b0;
      tmo_hit   = 1'b0;
      tmo_inc   = 1'b0;
      end_chk   = 1'b0;
      cmpl_set  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_q      <= 1'b0;
      mode4_q    <= 1'b0;
      byte_q     <= '0;
      sub_q      <= '0;
      bcnt_q     <= '0;
      crcbit_q   <= '0;
      tmo_q      <= '0;
      rx_crc_q   <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      complete_o <= 1'b0;
      crc_err_o  <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      clk_q      <= bitclk_i;
      valid_o    <= 1'b0;
      complete_o <= cmpl_set;
      if (start_acc) begin
        mode4_q   <= mode_4bit_i;
        crc_err_o <= 1'b0;
        timeout_o <= 1'b0;
        tmo_q     <= '0;
        sub_q     <= '0;
        bcnt_q    <= '0;
        crcbit_q  <= '0;
      end
      if (tmo_inc) tmo_q <= tmo_nxt;
      if (tmo_hit) timeout_o <= 1'b1;
      if (data_edge) begin
        byte_q <= byte_nxt;
        sub_q  <= byte_done ? 3'd0 : sub_q + 3'd1;
      end
      if (byte_done) begin
        data_o  <= byte_nxt;
        valid_o <= 1'b1;
        bcnt_q  <= bcnt_q + BCNT_W'(1);
      end
      if (crc_edge) begin
        for (int l = 0; l < 4; l++) rx_crc_q[l] <= {rx_crc_q[l][CRC_LEN-2:0], dat_i[l]};
        crcbit_q <= crcbit_q + 4'd1;
      end
      if (end_chk) crc_err_o <= crc_bad;
    end
  end

endmodule

// File: tb/tb_mmc_dat_deserialiser.sv
`timescale 1ns/1ps
module tb_mmc_dat_deserialiser;

  localparam int BB = 512;
  localparam int TW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bitclk = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       mode4 = 1'b0;
  logic [3:0] dat = 4'hF;
  logic [7:0] data_o;
  logic       valid_o, active_o, complete_o, crc_err_o, timeout_o;

  mmc_dat_deserialiser #(.BLOCK_BYTES(BB), .TIMEOUT_W(TW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bitclk_i   (bitclk),
    .start_i    (start),
    .abort_i    (abort),
    .mode_4bit_i(mode4),
    .dat_i      (dat),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .active_o   (active_o),
    .complete_o (complete_o),
    .crc_err_o  (crc_err_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: logs every byte strobe and completion with its cycle.
  logic [7:0] rx_mem [4096];
  int         rx_cyc [4096];
  int         rx_cnt = 0;
  int         comp_cnt = 0;
  int         comp_cyc = 0;
  int         both_cnt = 0;
  always @(negedge clk) begin
    if (valid_o) begin
      rx_mem[rx_cnt] <= data_o;
      rx_cyc[rx_cnt] <= cyc;
      rx_cnt         <= rx_cnt + 1;
    end
    if (complete_o) begin
      comp_cnt <= comp_cnt + 1;
      comp_cyc <= cyc;
    end
    if (valid_o && complete_o) both_cnt <= both_cnt + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0]  blk [BB];
  logic [15:0] tx_crc [4];
  int          edge_cyc;
  int          fb_edge;
  int          end_edge;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit period of 4 clk cycles; DAT changes while bitclk is low.
  task automatic bit_cycle(input logic [3:0] d);
    dat    = d;
    bitclk = 1'b0;
    tick();
    tick();
    bitclk   = 1'b1;
    edge_cyc = cyc;
    tick();
    tick();
  endtask

  function automatic logic [3:0] noise1(input logic b);
    logic [2:0] r;
    r = 3'($urandom);
    return {r, b};
  endfunction

  // Reference CRC as polynomial long division of the line's bit stream by x^16+x^12+x^5+1.
  function automatic logic [15:0] ref_crc(input bit m4, input int line);
    bit          q[$];
    logic [16:0] g;
    logic [15:0] r;
    int          n;
    g = 17'h11021;
    for (int i = 0; i < BB; i++) begin
      if (m4) begin
        q.push_back(blk[i][4+line]);
        q.push_back(blk[i][line]);
      end else begin
        for (int b = 7; b >= 0; b--) q.push_back(blk[i][b]);
      end
    end
    n = q.size();
    repeat (16) q.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (q[i]) for (int k = 0; k < 17; k++) q[i+k] ^= g[16-k];
    for (int k = 0; k < 16; k++) r[15-k] = q[n+k];
    return r;
  endfunction

  task automatic fill_crc(input bit m4);
    for (int l = 0; l < 4; l++) tx_crc[l] = ref_crc(m4, l);
  endtask

  task automatic fill_random();
    for (int i = 0; i < BB; i++) blk[i] = 8'($urandom);
  endtask

  // Drives a block; stop_after >= 0 returns right after that many bytes.
  task automatic send_block(input bit m4, input int stop_after, input bit endv);
    logic [3:0] d;
    mode4 = m4;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode4 = 1'($urandom);
    repeat ($urandom_range(0, 4)) bit_cycle(m4 ? 4'hF : noise1(1'b1));
    bit_cycle(m4 ? 4'h0 : noise1(1'b0));
    for (int i = 0; i < BB; i++) begin
      if (i == stop_after) return;
      if (m4) begin
        bit_cycle(blk[i][7:4]);
        bit_cycle(blk[i][3:0]);
      end else begin
        for (int b = 7; b >= 0; b--) bit_cycle(noise1(blk[i][b]));
      end
      if (i == 0) fb_edge = edge_cyc;
    end
    for (int k = 15; k >= 0; k--) begin
      d = {tx_crc[3][k], tx_crc[2][k], tx_crc[1][k], tx_crc[0][k]};
      bit_cycle(m4 ? d : noise1(d[0]));
    end
    bit_cycle(m4 ? (endv ? 4'hF : 4'h7) : noise1(endv));
    end_edge = edge_cyc;
    repeat (4) tick();
  endtask

  task automatic check_block(input string tag, input bit exp_err, input int rx0, input int cp0);
    int bad;
    bad = 0;
    chk({tag, "_nbytes"}, rx_cnt - rx0, BB);
    for (int i = 0; i < BB; i++) if (rx_mem[rx0+i] !== blk[i]) bad++;
    chk({tag, "_byte_mismatches"}, bad, 0);
    chk({tag, "_complete_cnt"}, comp_cnt - cp0, 1);
    chk({tag, "_crc_err"}, crc_err_o, exp_err);
    chk({tag, "_first_valid_lat"}, rx_cyc[rx0] - fb_edge, 1);
    chk({tag, "_complete_lat"}, comp_cyc - end_edge, 2);
    chk({tag, "_active_after"}, active_o, 0);
    chk({tag, "_valid_and_complete"}, both_cnt, 0);
  endtask

  int rx0, cp0, fl, fbit;

  initial begin
    repeat (3) tick();
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_active", active_o, 0);
    chk("rst_complete", complete_o, 0);
    chk("rst_crc_err", crc_err_o, 0);
    chk("rst_timeout", timeout_o, 0);
    rst_n = 1'b1;
    tick();

    // 1-bit, all 0xFF, known CRC
    for (int i = 0; i < BB; i++) blk[i] = 8'hFF;
    tx_crc[0] = 16'h7FA1;
    tx_crc[1] = 16'h0; tx_crc[2] = 16'h0; tx_crc[3] = 16'h0;
    rx0 = rx_cnt; cp0 = comp_cnt;
    send_block(1'b0, -1, 1'b1);
    check_block("ff1", 1'b0, rx0, cp0);

    // 4-bit, incrementing bytes
    for (int i = 0; i < BB; i++) blk[i] = 8'(i);
    fill_crc(1'b1);
    rx0 = rx_cnt; cp0 = comp_cnt;
    send_block(1'b1, -1, 1'b1);
    check_block("inc4", 1'b0, rx0, cp0);

    // same block, line 2 CRC bit 5 flipped
    tx_crc[2] = tx_crc[2] ^ 16'h0020;
    rx0 = rx_cnt; cp0 = comp_cnt;
    send_block(1'b1, -1, 1'b1);
    check_block("flip4", 1'b1, rx0, cp0);

    // 1-bit, good CRC, end bit low
    fill_random();
    fill_crc(1'b0);
    rx0 = rx_cnt; cp0 = comp_cnt;
    send_block(1'b0, -1, 1'b0);
    check_block("endbit1", 1'b1, rx0, cp0);

    // timeout: no start bit
    cp0 = comp_cnt;
    mode4 = 1'b0; start = 1'b1; tick(); start = 1'b0;
    repeat (14) bit_cycle(4'hF);
    chk("tmo_active_before", active_o, 1);
    chk("tmo_flag_before", timeout_o, 0);
    bit_cycle(4'hF);
    chk("tmo_flag", timeout_o, 1);
    chk("tmo_active", active_o, 0);
    chk("tmo_no_complete", comp_cnt - cp0, 0);
    chk("tmo_crc_err", crc_err_o, 0);

    // abort after byte 100, then a clean restart
    fill_random();
    fill_crc(1'b1);
    rx0 = rx_cnt; cp0 = comp_cnt;
    send_block(1'b1, 100, 1'b1);
    chk("abort_bytes_before", rx_cnt - rx0, 100);
    chk("abort_tmo_cleared", timeout_o, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_active", active_o, 0);
    repeat (6) bit_cycle(4'($urandom));
    chk("abort_bytes_after", rx_cnt - rx0, 100);
    chk("abort_no_complete", comp_cnt - cp0, 0);
    fl = 0;
    for (int i = 0; i < 100; i++) if (rx_mem[rx0+i] !== blk[i]) fl++;
    chk("abort_byte_mismatches", fl, 0);
    fill_random();
    fill_crc(1'b1);
    rx0 = rx_cnt; cp0 = comp_cnt;
    send_block(1'b1, -1, 1'b1);
    check_block("restart4", 1'b0, rx0, cp0);

    // reset mid-DATA
    fill_random();
    fill_crc(1'b1);
    send_block(1'b1, 20, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_data", data_o, 0);
    chk("mrst_valid", valid_o, 0);
    chk("mrst_active", active_o, 0);
    chk("mrst_complete", complete_o, 0);
    chk("mrst_timeout", timeout_o, 0);
    tick();
    rst_n = 1'b1;
    rx0 = rx_cnt; cp0 = comp_cnt;
    repeat (40) bit_cycle(4'($urandom));
    chk("mrst_no_strobes", rx_cnt - rx0, 0);
    chk("mrst_no_complete", comp_cnt - cp0, 0);

    // random 1-bit clean block with noise on DAT[3:1]
    fill_random();
    fill_crc(1'b0);
    rx0 = rx_cnt; cp0 = comp_cnt;
    send_block(1'b0, -1, 1'b1);
    check_block("rand1", 1'b0, rx0, cp0);

    // random 4-bit block with a random CRC bit error
    fill_random();
    fill_crc(1'b1);
    fl   = $urandom_range(0, 3);
    fbit = $urandom_range(0, 15);
    tx_crc[fl] = tx_crc[fl] ^ (16'h1 << fbit);
    rx0 = rx_cnt; cp0 = comp_cnt;
    send_block(1'b1, -1, 1'b1);
    check_block("randflip4", 1'b1, rx0, cp0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
